// File: rtl/noc_echo_responder.sv
// NoC echo/register responder: queues requests in a small FIFO, executes them one at a
// time (echo, register write/read, nop) and returns responses in request order.
module noc_echo_responder #(
    parameter int unsigned WIDTH_DATA    = 492,
    parameter int unsigned ADDRESS_WIDTH = 4,
    parameter int unsigned NODE_ID       = 15,
    parameter int unsigned REG_DEPTH     = 12,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH_DATA-1:0]    i_data_in,
    input  logic [ADDRESS_WIDTH-1:0] i_src_in,
    input  logic                     i_valid_in,
    output logic                     i_ready_out,
    output logic [WIDTH_DATA-1:0]    o_data_out,
    output logic [ADDRESS_WIDTH-1:0] o_dest_out,
    output logic                     o_valid_out,
    input  logic                     o_ready_in,
    output logic [15:0]              o_req_count,
    output logic [15:0]              o_nop_count
);

    localparam int unsigned W       = WIDTH_DATA;
    localparam int unsigned ENTRY_W = ADDRESS_WIDTH + WIDTH_DATA;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;

    if ((REG_DEPTH < 1) || (REG_DEPTH > 16)) begin : g_bad_reg_depth
        $error("noc_echo_responder: REG_DEPTH must be in 1..16");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
        $error("noc_echo_responder: FIFO_DEPTH must be a power of two >= 2");
    end
    if ((NODE_ID >> ADDRESS_WIDTH) != 0) begin : g_bad_node_id
        $error("noc_echo_responder: NODE_ID does not fit in ADDRESS_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_SEND = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_ECHO  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } opcode_t;

    state_t state;

    // Request FIFO
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   fifo_count_next;
    logic               ready_q;
    logic               push;
    logic               pop;

    assign i_ready_out = ready_q;
    assign push        = i_valid_in && ready_q;
    assign pop         = (state == S_IDLE) && (fifo_count != '0);

    always_comb begin
        fifo_count_next = fifo_count;
        case ({push, pop})
            2'b10:   fifo_count_next = fifo_count + 1'b1;
            2'b01:   fifo_count_next = fifo_count - 1'b1;
            default: fifo_count_next = fifo_count;
        endcase
    end

    // Ready is registered from next occupancy, so o_ready_in never reaches it combinationally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ready_q    <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {i_src_in, i_data_in};
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count_next;
            ready_q    <= (fifo_count_next != CNT_W'(FIFO_DEPTH));
        end
    end

    // Working request and its decoded fields
    logic [W-1:0]             work_data;
    logic [ADDRESS_WIDTH-1:0] work_src;
    opcode_t                  work_op;
    logic [7:0]               work_tag;
    logic [3:0]               work_idx;
    logic [31:0]              work_payload;
    logic                     idx_ok;

    assign work_op      = opcode_t'(work_data[W-1 -: 2]);
    assign work_tag     = work_data[W-3 -: 8];
    assign work_idx     = work_data[35:32];
    assign work_payload = work_data[31:0];
    assign idx_ok       = (32'(work_idx) < REG_DEPTH);

    logic [31:0] regs [REG_DEPTH];
    logic [31:0] rd_val;
    logic [W-1:0] resp;

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < REG_DEPTH; i++) begin
            if (32'(work_idx) == i) begin
                rd_val = regs[i];
            end
        end
    end

    // Register-op response: opcode/tag/status/result, every other bit forced low.
    always_comb begin
        resp           = '0;
        resp[W-1 -: 2] = work_op;
        resp[W-3 -: 8] = work_tag;
        resp[W-11]     = !idx_ok;
        if (idx_ok) begin
            resp[31:0] = (work_op == OP_WRITE) ? work_payload : rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            work_data   <= '0;
            work_src    <= '0;
            o_data_out  <= '0;
            o_dest_out  <= '0;
            o_valid_out <= 1'b0;
            o_req_count <= '0;
            o_nop_count <= '0;
            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (push && (o_req_count != 16'hFFFF)) begin
                o_req_count <= o_req_count + 16'd1;
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {work_src, work_data} <= fifo_mem[rd_ptr];
                        state                 <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (work_op == OP_NOP) begin
                        o_nop_count <= o_nop_count + 16'd1;
                        state       <= S_IDLE;
                    end else begin
                        if ((work_op == OP_WRITE) && idx_ok) begin
                            for (int unsigned i = 0; i < REG_DEPTH; i++) begin
                                if (32'(work_idx) == i) begin
                                    regs[i] <= work_payload;
                                end
                            end
                        end
                        o_data_out  <= (work_op == OP_ECHO) ? work_data : resp;
                        o_dest_out  <= work_src;
                        o_valid_out <= 1'b1;
                        state       <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (o_ready_in) begin
                        o_valid_out <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_echo_responder.sv
// Self-checking bench for noc_echo_responder: directed scenarios plus a randomized
// mix checked against a queue-based behavioural model.
module tb_noc_echo_responder;

    localparam int W  = 492;
    localparam int AW = 4;
    localparam int RD = 12;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  i_data_in = '0;
    logic [AW-1:0] i_src_in = '0;
    logic          i_valid_in = 1'b0;
    logic          i_ready_out;
    logic [W-1:0]  o_data_out;
    logic [AW-1:0] o_dest_out;
    logic          o_valid_out;
    logic          o_ready_in = 1'b0;
    logic [15:0]   o_req_count;
    logic [15:0]   o_nop_count;

    always #5 clk = ~clk;

    noc_echo_responder #(
        .WIDTH_DATA(W),
        .ADDRESS_WIDTH(AW),
        .NODE_ID(15),
        .REG_DEPTH(RD),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_data_in(i_data_in),
        .i_src_in(i_src_in),
        .i_valid_in(i_valid_in),
        .i_ready_out(i_ready_out),
        .o_data_out(o_data_out),
        .o_dest_out(o_dest_out),
        .o_valid_out(o_valid_out),
        .o_ready_in(o_ready_in),
        .o_req_count(o_req_count),
        .o_nop_count(o_nop_count)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [AW+W-1:0] exp_q[$];
    logic [AW+W-1:0] obs_q[$];
    logic [31:0]     ref_regs [16];
    int              ref_req;
    int              ref_nop;

    // A response is taken when valid and ready are both high at the coming edge.
    always @(negedge clk) begin
        if (rst && o_valid_out && o_ready_in) obs_q.push_back({o_dest_out, o_data_out});
    end

    initial begin
        #800000;
        $display("FAIL watchdog sim_time got expired required finished");
        $fatal(1);
    end

    function automatic logic [W-1:0] mk_req(input logic [1:0] op, input logic [7:0] tag,
                                            input logic [3:0] idx, input logic [31:0] pl);
        logic [W-1:0] d;
        for (int i = 0; i < W; i++) d[i] = 1'($urandom_range(0, 1));
        d[W-1:W-2] = op;
        d[W-3:W-10] = tag;
        d[35:32] = idx;
        d[31:0] = pl;
        return d;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;
        ref_req = 0;
        ref_nop = 0;
    endfunction

    function automatic void model_accept(input logic [W-1:0] d, input logic [AW-1:0] s);
        logic [1:0]  op;
        logic [7:0]  tag;
        logic [3:0]  idx;
        logic [31:0] pl;
        op  = d[W-1:W-2];
        tag = d[W-3:W-10];
        idx = d[35:32];
        pl  = d[31:0];
        if (ref_req < 65535) ref_req++;
        case (op)
            2'b00: exp_q.push_back({s, d});
            2'b01: begin
                if (idx < RD) begin
                    ref_regs[idx] = pl;
                    exp_q.push_back({s, op, tag, 1'b0, {(W-43){1'b0}}, pl});
                end else begin
                    exp_q.push_back({s, op, tag, 1'b1, {(W-43){1'b0}}, 32'h0});
                end
            end
            2'b10: begin
                if (idx < RD) exp_q.push_back({s, op, tag, 1'b0, {(W-43){1'b0}}, ref_regs[idx]});
                else          exp_q.push_back({s, op, tag, 1'b1, {(W-43){1'b0}}, 32'h0});
            end
            default: ref_nop = (ref_nop + 1) % 65536;
        endcase
    endfunction

    // Offers one request and waits (bounded) for it to be accepted; returns at edge+1.
    task automatic send(input logic [W-1:0] d, input logic [AW-1:0] s);
        bit acc;
        i_data_in  = d;
        i_src_in   = s;
        i_valid_in = 1'b1;
        for (int n = 0; n < 300; n++) begin
            acc = i_ready_out;
            @(posedge clk); #1;
            if (acc) begin
                i_valid_in = 1'b0;
                model_accept(d, s);
                return;
            end
        end
        i_valid_in = 1'b0;
        n_cmp++; n_fail++;
        $display("FAIL send_accept ready got 0 required 1 within 300 cycles");
    endtask

    task automatic wait_resp(input int budget);
        for (int n = 0; n < budget && obs_q.size() < exp_q.size(); n++) begin
            @(posedge clk); #1;
        end
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        i_valid_in = 1'b0;
        o_ready_in = 1'b0;
        i_data_in = '0;
        i_src_in = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        n_cmp++; if (i_ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b required 0", i_ready_out); end
        n_cmp++; if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b required 0", o_valid_out); end
        n_cmp++; if (o_data_out !== '0) begin n_fail++; $display("FAIL rst_data got %h required 0", o_data_out); end
        n_cmp++; if (o_dest_out !== '0) begin n_fail++; $display("FAIL rst_dest got %h required 0", o_dest_out); end
        n_cmp++; if (o_req_count !== 16'h0 || o_nop_count !== 16'h0) begin
            n_fail++; $display("FAIL rst_counts got %h/%h required 0/0", o_req_count, o_nop_count);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (i_ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready_first_edge got %b required 1", i_ready_out); end
        model_reset();
    endtask

    task automatic test_echo_latency();
        logic [W-1:0] d;
        apply_reset();
        o_ready_in = 1'b1;
        d = mk_req(2'b00, 8'($urandom), 4'($urandom), 32'($urandom));
        d[15:0] = 16'hABCD;
        send(d, '0);
        n_cmp++; if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL echo_valid_edge0 got %b required 0", o_valid_out); end
        @(posedge clk); #1;
        n_cmp++; if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL echo_valid_edge1 got %b required 0", o_valid_out); end
        @(posedge clk); #1;
        n_cmp++; if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL echo_valid_edge2 got %b required 1", o_valid_out); end
        n_cmp++; if (o_data_out !== d) begin n_fail++; $display("FAIL echo_data got %h required %h", o_data_out, d); end
        n_cmp++; if (o_dest_out !== '0) begin n_fail++; $display("FAIL echo_dest got %h required 0", o_dest_out); end
        @(posedge clk); #1;
        n_cmp++; if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL echo_valid_edge3 got %b required 0", o_valid_out); end
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL echo_count got %0d required 1", obs_q.size()); end
    endtask

    task automatic test_write_read();
        logic [AW+W-1:0] r;
        apply_reset();
        o_ready_in = 1'b1;
        send(mk_req(2'b01, 8'h5A, 4'd3, 32'hDEADBEEF), 4'd7);
        send(mk_req(2'b10, 8'h5A, 4'd3, 32'($urandom)), 4'd7);
        send(mk_req(2'b10, 8'($urandom), 4'd13, 32'($urandom)), 4'($urandom));
        send(mk_req(2'b01, 8'($urandom), 4'd15, 32'($urandom)), 4'($urandom));
        send(mk_req(2'b10, 8'($urandom), 4'd3, 32'($urandom)), 4'd15);
        wait_resp(100);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL wr_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL wr_resp%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() >= 5) begin
            r = obs_q[1];
            n_cmp++; if (r[AW+W-1:W] !== 4'd7 || r[31:0] !== 32'hDEADBEEF || r[W-3:W-10] !== 8'h5A || r[W-11] !== 1'b0) begin
                n_fail++; $display("FAIL read_idx3 got dest %h res %h tag %h st %b required 7/deadbeef/5a/0", r[AW+W-1:W], r[31:0], r[W-3:W-10], r[W-11]);
            end
            r = obs_q[2];
            n_cmp++; if (r[W-11] !== 1'b1 || r[31:0] !== 32'h0) begin
                n_fail++; $display("FAIL read_idx13 got st %b res %h required 1/0", r[W-11], r[31:0]);
            end
            r = obs_q[3];
            n_cmp++; if (r[W-11] !== 1'b1 || r[31:0] !== 32'h0) begin
                n_fail++; $display("FAIL write_idx15 got st %b res %h required 1/0", r[W-11], r[31:0]);
            end
            r = obs_q[4];
            n_cmp++; if (r[31:0] !== 32'hDEADBEEF) begin
                n_fail++; $display("FAIL reread_idx3 got %h required deadbeef", r[31:0]);
            end
        end
        n_cmp++; if (o_req_count !== 16'd5) begin n_fail++; $display("FAIL wr_req_count got %0d required 5", o_req_count); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0]  d [6];
        logic [AW-1:0] s;
        int k;
        bit acc;
        int bad;
        apply_reset();
        o_ready_in = 1'b0;
        s = 4'($urandom);
        for (int i = 0; i < 6; i++) d[i] = mk_req(2'b00, 8'($urandom), 4'($urandom), 32'($urandom));
        k = 0;
        i_src_in = s;
        i_data_in = d[0];
        i_valid_in = 1'b1;
        for (int c = 0; c < 40 && k < 5; c++) begin
            acc = i_ready_out;
            @(posedge clk); #1;
            if (acc) begin
                model_accept(d[k], s);
                k++;
                i_data_in = d[k];
            end
        end
        n_cmp++; if (k !== 5) begin n_fail++; $display("FAIL b2b_accepts got %0d required 5", k); end
        n_cmp++; if (i_ready_out !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %b required 0", i_ready_out); end
        bad = 0;
        repeat (4) begin
            acc = i_ready_out;
            @(posedge clk); #1;
            if (acc || o_valid_out !== 1'b1 || o_data_out !== d[0] || o_dest_out !== s) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_hold got %0d unstable cycles required 0", bad); end
        o_ready_in = 1'b1;
        send(d[5], s);
        wait_resp(100);
        n_cmp++; if (obs_q.size() !== 6) begin n_fail++; $display("FAIL b2b_count got %0d required 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_resp%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++; if (o_req_count !== 16'd6) begin n_fail++; $display("FAIL b2b_req_count got %0d required 6", o_req_count); end
    endtask

    task automatic test_nop();
        logic [W-1:0] e;
        apply_reset();
        o_ready_in = 1'b1;
        for (int i = 0; i < 3; i++) send(mk_req(2'b11, 8'($urandom), 4'($urandom), 32'($urandom)), 4'($urandom));
        e = mk_req(2'b00, 8'($urandom), 4'($urandom), 32'($urandom));
        send(e, 4'd15);
        wait_resp(100);
        n_cmp++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL nop_resp_count got %0d required 1", obs_q.size()); end
        n_cmp++; if (obs_q.size() > 0 && obs_q[0] !== {4'd15, e}) begin
            n_fail++; $display("FAIL nop_echo got %h required %h", obs_q[0], {4'd15, e});
        end
        n_cmp++; if (o_nop_count !== 16'd3) begin n_fail++; $display("FAIL nop_count got %0d required 3", o_nop_count); end
        n_cmp++; if (o_req_count !== 16'd4) begin n_fail++; $display("FAIL nop_req_count got %0d required 4", o_req_count); end
    endtask

    task automatic test_random();
        bit done;
        apply_reset();
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send(mk_req(2'($urandom), 8'($urandom), 4'($urandom), 32'($urandom)), 4'($urandom));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    o_ready_in = ($urandom_range(0, 9) < 7);
                end
            end
        join
        o_ready_in = 1'b1;
        wait_resp(800);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL rnd_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rnd_resp%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_cmp++; if (o_req_count !== 16'(ref_req)) begin n_fail++; $display("FAIL rnd_req_count got %0d required %0d", o_req_count, ref_req); end
        n_cmp++; if (o_nop_count !== 16'(ref_nop)) begin n_fail++; $display("FAIL rnd_nop_count got %0d required %0d", o_nop_count, ref_nop); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        o_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) send(mk_req(2'b00, 8'($urandom), 4'($urandom), 32'($urandom)), 4'($urandom));
        n_cmp++; if (o_valid_out !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before got %b required 1", o_valid_out); end
        #3;
        rst = 1'b0;
        #1;
        n_cmp++; if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid_drop got %b required 0", o_valid_out); end
        n_cmp++; if (o_req_count !== 16'h0 || o_nop_count !== 16'h0) begin
            n_fail++; $display("FAIL mid_counts got %h/%h required 0/0", o_req_count, o_nop_count);
        end
        n_cmp++; if (i_ready_out !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b required 0", i_ready_out); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        o_ready_in = 1'b1;
        repeat (12) begin @(posedge clk); #1; end
        n_cmp++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL mid_no_resp got %0d required 0", obs_q.size()); end
        n_cmp++; if (o_valid_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid_after got %b required 0", o_valid_out); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_echo_latency();
        test_write_read();
        test_back_to_back();
        test_nop();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/noc_echo_responder.md
NOC_ECHO_RESPONDER -- requirements
Module: noc_echo_responder

Interface
REQ-001 SHALL have parameter WIDTH_DATA, default 492, the request/response payload width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4, the node address width.
REQ-003 SHALL have parameter NODE_ID, default 15, the responder's own node address.
REQ-004 SHALL have parameter REG_DEPTH, default 12, the number of 32-bit registers (1..16).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, the request FIFO depth (power of two, >=2).
REQ-006 SHALL have port clk, input, 1, the single clock for all logic.
REQ-007 SHALL have port rst, input, 1, a reset that is asynchronous and active-low.
REQ-008 SHALL have port i_data_in, input, WIDTH_DATA, the request payload from the depacketizer side.
REQ-009 SHALL have port i_src_in, input, ADDRESS_WIDTH, the requesting node's address.
REQ-010 SHALL have port i_valid_in, input, 1, the request valid.
REQ-011 SHALL have port i_ready_out, output, 1, the request ready.
REQ-012 SHALL have port o_data_out, output, WIDTH_DATA, the response payload to the packetizer side.
REQ-013 SHALL have port o_dest_out, output, ADDRESS_WIDTH, the response destination.
REQ-014 SHALL have port o_valid_out, output, 1, the response valid.
REQ-015 SHALL have port o_ready_in, input, 1, the response ready.
REQ-016 SHALL have port o_req_count, output, 16, the count of accepted requests (saturating at 0xFFFF).
REQ-017 SHALL have port o_nop_count, output, 16, the count of NOP requests (wraps modulo 2^16).

Function
REQ-018 Request fields SHALL be: opcode = i_data_in[W-1:W-2]; tag = [W-3:W-10]; index = [35:32]; payload = [31:0] (W = WIDTH_DATA).
REQ-019 Opcodes SHALL be: 00 ECHO, 01 WRITE, 10 READ, 11 NOP.
REQ-020 A request SHALL be accepted on a rising clk edge where i_valid_in && i_ready_out, and {i_src_in, i_data_in} SHALL be pushed into the request FIFO.
REQ-021 i_ready_out SHALL equal !fifo_full; there SHALL be no combinational path from o_ready_in to i_ready_out.
REQ-022 The FSM SHALL have states IDLE, EXEC and SEND.
REQ-023 In IDLE, if the FIFO is non-empty, the FSM SHALL pop the head into a working register and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-024 In EXEC, the FSM SHALL execute the working request; for NOP it SHALL increment o_nop_count and return to IDLE with no response; for any other opcode it SHALL load the output register, set o_valid_out=1 and go to SEND.
REQ-025 In SEND, the FSM SHALL hold o_data_out, o_dest_out and o_valid_out stable until the edge where o_ready_in=1, then clear o_valid_out and go to IDLE.
REQ-026 ECHO SHALL set o_data_out = the request data unchanged.
REQ-027 WRITE and READ responses SHALL have: opcode and tag copied from the request; bit [W-11] = status; [31:0] = result; all other bits 0.
REQ-028 WRITE with index < REG_DEPTH SHALL write reg[index] = payload, with result = payload and status = 0.
REQ-029 READ with index < REG_DEPTH SHALL return result = reg[index], with status = 0.
REQ-030 WRITE or READ with index >= REG_DEPTH SHALL set status = 1 and result = 0, and SHALL NOT modify any register.
REQ-031 o_dest_out SHALL be the request's i_src_in, including when it equals NODE_ID.
REQ-032 Latency: a request accepted with the FIFO empty and the FSM in IDLE SHALL produce o_valid_out=1 after the 2nd rising edge following acceptance.
REQ-033 Peak throughput SHALL be one response per 3 cycles; responses SHALL leave in request order.
REQ-034 A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged.
REQ-035 When the FIFO is full, a push SHALL be allowed in the same cycle as a pop only if i_ready_out was already high; since ready is registered from occupancy, a full FIFO SHALL hold i_ready_out=0 for that cycle.
REQ-036 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-037 o_req_count SHALL increment once per accepted request, counting NOPs, and SHALL saturate at 0xFFFF.

Reset
REQ-038 While rst=0, asynchronously: the FSM SHALL go to IDLE; the FIFO SHALL empty; all registers SHALL clear to 0; o_data_out=0, o_dest_out=0, o_valid_out=0, o_req_count=0, o_nop_count=0; i_ready_out SHALL be 0.
REQ-039 After rst deasserts, i_ready_out SHALL be 1 from the first rising edge, and a reset applied mid-transfer SHALL discard all queued and in-flight requests without emitting a response.

Verification
REQ-040 Bench SHALL send ECHO with data = 0x...ABCD (opcode 00) from src 0 with o_ready_in=1 -> identical data and o_dest_out=0 with o_valid_out after the 2nd edge, held 1 cycle.
REQ-041 Bench SHALL send WRITE idx 3 = 0xDEADBEEF with tag 0x5A, then READ idx 3 from src 7 -> two responses to dest 7, status 0, the READ returning result 0xDEADBEEF and tag 0x5A.
REQ-042 Bench SHALL send READ idx 13 and WRITE idx 15 -> status 1 and result 0 for both, with reg contents unchanged on a later READ.
REQ-043 Bench SHALL hold o_ready_in=0 and send 6 ECHOs back-to-back -> i_ready_out=0 after 5 accepts (1 in SEND + 4 in FIFO); on releasing ready, all 6 SHALL emerge in order and o_req_count = 6.
REQ-044 Bench SHALL send 3 NOPs followed by 1 ECHO -> only 1 response, o_nop_count = 3, o_req_count = 4.
REQ-045 Bench SHALL assert rst=0 while in SEND with 2 requests queued -> o_valid_out drops immediately, counters = 0, and no response appears after release.
